apu_frame_sequencer: RTL and testbench

//  Frame sequencer driving the pulse channels' qtr_clk and hlf_clk tick inputs.
//  - Divides apu_clk into steps of STEP_PERIOD cycles.
//  - Runs the 4-step or 5-step frame pattern (NES $4017 semantics).
//  - Raises the frame IRQ.
//  - Handles software writes that reset or resync the frame.

---
 rtl/apu_frame_sequencer_if.sv | 12 +
 rtl/apu_frame_sequencer.sv | 48 ++++
 tb/tb_apu_frame_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/apu_frame_sequencer_if.sv
// apu_frame_sequencer_if: frame-control write/ack strobes and tick/IRQ/step outputs of the frame sequencer
interface apu_frame_sequencer_if;
  logic       cfg_wr;
  logic [7:0] cfg_data;
  logic       irq_ack;
  logic       qtr_tick;
  logic       hlf_tick;
  logic       frame_irq;
  logic [2:0] step;
  modport master (output cfg_wr, cfg_data, irq_ack, input qtr_tick, hlf_tick, frame_irq, step);
  modport slave  (input cfg_wr, cfg_data, irq_ack, output qtr_tick, hlf_tick, frame_irq, step);
endinterface

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: divides apu_clk into frame steps and issues quarter/half-frame ticks and the frame IRQ
module apu_frame_sequencer #(
  parameter int STEP_PERIOD = 3729,
  parameter int CNT_W       = 12
) (
  input logic                 apu_clk,
  input logic                 rst,
  apu_frame_sequencer_if.slave bus
);
  logic [CNT_W-1:0] div_q;
  logic [2:0]       step_q;
  logic             mode_q, inh_q, qtr_q, hlf_q, irq_q;
  logic             tc, last, qtr_en, hlf_en;
  assign tc     = div_q == CNT_W'(STEP_PERIOD - 1);
  assign last   = mode_q ? step_q == 3'd4 : step_q == 3'd3;
  assign qtr_en = mode_q ? step_q != 3'd3 : 1'b1;
  assign hlf_en = step_q == 3'd1 || last;
  assign bus.qtr_tick  = qtr_q;
  assign bus.hlf_tick  = hlf_q;
  assign bus.frame_irq = irq_q;
  assign bus.step      = step_q;
  // a frame-control write restarts the frame and beats any coincident terminal-count action
  always_ff @(posedge apu_clk) begin
    if (rst) begin
      div_q  <= '0;
      step_q <= '0;
      mode_q <= 1'b0;
      inh_q  <= 1'b0;
      qtr_q  <= 1'b0;
      hlf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else if (bus.cfg_wr) begin
      mode_q <= bus.cfg_data[7];
      inh_q  <= bus.cfg_data[6];
      div_q  <= '0;
      step_q <= '0;
      qtr_q  <= bus.cfg_data[7];
      hlf_q  <= bus.cfg_data[7];
      irq_q  <= irq_q && !bus.cfg_data[6] && !bus.irq_ack;
    end else begin
      div_q  <= tc ? '0 : div_q + CNT_W'(1);
      step_q <= tc ? (last ? 3'd0 : step_q + 3'd1) : step_q;
      qtr_q  <= tc && qtr_en;
      hlf_q  <= tc && hlf_en;
      irq_q  <= (tc && last && !mode_q && !inh_q) || (irq_q && !bus.irq_ack);
    end
  end
endmodule

// File: tb/tb_apu_frame_sequencer.sv
// tb_apu_frame_sequencer: directed table and sequence checks of the frame sequencer with STEP_PERIOD=4
module tb_apu_frame_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       ack;
    logic       q;
    logic       h;
    logic       irq;
    logic [2:0] st;
  } vec_t;
  vec_t tv[24];
  apu_frame_sequencer_if bus ();
  apu_frame_sequencer #(.STEP_PERIOD(4), .CNT_W(3)) dut (.apu_clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask
  task automatic chk_all(input string name, input logic q, input logic h, input logic irq, input logic [2:0] st);
    chk({name, ".qtr"}, int'(bus.qtr_tick), int'(q));
    chk({name, ".hlf"}, int'(bus.hlf_tick), int'(h));
    chk({name, ".irq"}, int'(bus.frame_irq), int'(irq));
    chk({name, ".step"}, int'(bus.step), int'(st));
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
    bus.cfg_wr = 1'b0;
    bus.irq_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    cyc++;
  endtask
  task automatic go(input int n);
    while (cyc < n) nxt();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.cfg_wr = 1'b0;
    bus.cfg_data = 8'h00;
    bus.irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask
  task automatic clr_tv();
    foreach (tv[i]) tv[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
  endtask
  task automatic fill(input int lo, input int hi, input logic [2:0] st, input logic irq);
    for (int i = lo; i <= hi; i++) begin
      tv[i].st = st;
      tv[i].irq = irq;
    end
  endtask
  task automatic tick(input int i, input logic h);
    tv[i].q = 1'b1;
    tv[i].h = h;
  endtask
  task automatic run_tv(input string name, input int len);
    for (int k = 0; k < len; k++) begin
      chk_all(name, tv[k].q, tv[k].h, tv[k].irq, tv[k].st);
      bus.cfg_wr = tv[k].wr;
      bus.cfg_data = tv[k].d;
      bus.irq_ack = tv[k].ack;
      nxt();
    end
  endtask
  initial begin
    do_reset();
    clr_tv();
    fill(0, 3, 3'd0, 1'b0);
    fill(4, 7, 3'd1, 1'b0);
    fill(8, 11, 3'd2, 1'b0);
    fill(12, 15, 3'd3, 1'b0);
    fill(16, 19, 3'd0, 1'b1);
    tick(4, 1'b0);
    tick(8, 1'b1);
    tick(12, 1'b0);
    tick(16, 1'b1);
    run_tv("mode0", 20);
    do_reset();
    clr_tv();
    tv[1].wr = 1'b1;
    tv[1].d = 8'h80;
    fill(0, 5, 3'd0, 1'b0);
    fill(6, 9, 3'd1, 1'b0);
    fill(10, 13, 3'd2, 1'b0);
    fill(14, 17, 3'd3, 1'b0);
    fill(18, 21, 3'd4, 1'b0);
    fill(22, 23, 3'd0, 1'b0);
    tick(2, 1'b1);
    tick(6, 1'b0);
    tick(10, 1'b1);
    tick(14, 1'b0);
    tick(22, 1'b1);
    run_tv("mode1", 24);
    do_reset();
    chk_all("rst", 1'b0, 1'b0, 1'b0, 3'd0);
    go(16);
    chk_all("irq_set", 1'b1, 1'b1, 1'b1, 3'd0);
    go(31);
    bus.irq_ack = 1'b1;
    nxt();
    chk_all("ack_vs_set", 1'b1, 1'b1, 1'b1, 3'd0);
    bus.irq_ack = 1'b1;
    nxt();
    chk_all("lone_ack", 1'b0, 1'b0, 1'b0, 3'd0);
    go(48);
    chk_all("irq_set2", 1'b1, 1'b1, 1'b1, 3'd0);
    go(49);
    bus.cfg_wr = 1'b1;
    bus.cfg_data = 8'h40;
    nxt();
    chk_all("inhibit_wr", 1'b0, 1'b0, 1'b0, 3'd0);
    go(54);
    chk_all("inh_s1", 1'b1, 1'b0, 1'b0, 3'd1);
    go(58);
    chk_all("inh_s2", 1'b1, 1'b1, 1'b0, 3'd2);
    go(62);
    chk_all("inh_s3", 1'b1, 1'b0, 1'b0, 3'd3);
    go(66);
    chk_all("inh_wrap", 1'b1, 1'b1, 1'b0, 3'd0);
    go(67);
    chk("inh_hold.irq", int'(bus.frame_irq), 0);
    go(69);
    bus.cfg_wr = 1'b1;
    bus.cfg_data = 8'h00;
    nxt();
    chk_all("wr_at_tc", 1'b0, 1'b0, 1'b0, 3'd0);
    go(73);
    chk_all("wr_at_tc_pre", 1'b0, 1'b0, 1'b0, 3'd0);
    nxt();
    chk_all("wr_at_tc_next", 1'b1, 1'b0, 1'b0, 3'd1);
    go(80);
    chk("mid.step", int'(bus.step), 2);
    chk("mid.div", int'(dut.div_q), 2);
    rst = 1'b1;
    nxt();
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 3'd0);
    go(85);
    chk_all("rr_s1", 1'b1, 1'b0, 1'b0, 3'd1);
    nxt();
    chk_all("rr_single", 1'b0, 1'b0, 1'b0, 3'd1);
    go(89);
    chk_all("rr_s2", 1'b1, 1'b1, 1'b0, 3'd2);
    go(96);
    chk_all("rr_pre_irq", 1'b0, 1'b0, 1'b0, 3'd3);
    nxt();
    chk_all("rr_irq", 1'b1, 1'b1, 1'b1, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
